bus_arbiter_rr: RTL and testbench

- Parametrised successor to the two-master fixed arbiter in the system bus interconnect.
- Arbitrates NUM_MASTERS requesters onto a shared bus to NUM_SLAVES targets, using rotating (round-robin) priority.
- Latches the winner's slave selection and holds the grant until transaction completion or abort.
- Drives bus_grant/slave_sel for the bus mux; adds decode-error rejection and an optional hang watchdog.

---
 rtl/bus_arbiter_rr.sv | 186 ++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with slave decode check and optional grant watchdog
//
// Purpose:
//   Arbitrates NUM_MASTERS requesters onto one shared bus using rotating priority.
//   The winner's slave index is latched and held, together with the grant, until
//   the transaction completes (trans_done) or the master withdraws its request.
//   Requests that name a nonexistent slave are rejected with a decode_err pulse.
//
// Ports:
//   sys_clk       in   system clock, rising edge
//   sys_rst       in   asynchronous active-low reset
//   m_request     in   per-master level request
//   m_slave_sel   in   per-master slave index, master k at [k*SEL_W +: SEL_W]
//   trans_done    in   one-cycle end-of-transaction pulse
//   m_grant       out  registered one-hot grant
//   bus_grant     out  index of the granted master
//   slave_sel     out  latched slave index of the granted master
//   bus_valid     out  bus_grant/slave_sel meaningful (GRANT)
//   arbiter_busy  out  ARB or RELEASE
//   bus_busy      out  GRANT
//   decode_err    out  pulse in ARB when the winner selected a nonexistent slave
//   timeout       out  pulse when the watchdog forces a release
//
// Optional feature macro: ARB_TIMEOUT_EN builds the grant watchdog limited to
// TIMEOUT_CYCLES GRANT cycles; without it timeout is tied 0.
module bus_arbiter_rr #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 3,
  parameter int MST_W          = 1,
  parameter int SEL_W          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [NUM_MASTERS-1:0]       m_request,
  input  logic [NUM_MASTERS*SEL_W-1:0] m_slave_sel,
  input  logic                         trans_done,
  output logic [NUM_MASTERS-1:0]       m_grant,
  output logic [MST_W-1:0]             bus_grant,
  output logic [SEL_W-1:0]             slave_sel,
  output logic                         bus_valid,
  output logic                         arbiter_busy,
  output logic                         bus_busy,
  output logic                         decode_err,
  output logic                         timeout
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARB     = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // One extra bit so ptr + offset can exceed NUM_MASTERS before the wrap.
  localparam int IW = MST_W + 1;

  logic [1:0]             r_state;
  logic [MST_W-1:0]       r_ptr;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [MST_W-1:0]       r_owner;
  logic [SEL_W-1:0]       r_sel;

  logic                   w_found;
  logic [MST_W-1:0]       w_winner;
  logic [IW-1:0]          w_idx;
  logic [NUM_MASTERS-1:0] w_onehot;
  logic [SEL_W-1:0]       w_win_sel;
  logic                   w_bad_sel;
  logic                   w_owner_req;
  logic                   w_expire;
  logic                   w_release;

  // Rotate to the master after idx, with an explicit wrap so a non-power-of-two
  // master count never yields an out-of-range pointer.
  function automatic logic [MST_W-1:0] next_ptr(input logic [MST_W-1:0] idx);
    if (int'(idx) >= NUM_MASTERS - 1) return '0;
    return idx + MST_W'(1);
  endfunction

  // Search ptr, ptr+1, ... modulo NUM_MASTERS; the first requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_idx = {1'b0, r_ptr} + IW'(i);
      if (int'(w_idx) >= NUM_MASTERS) w_idx = w_idx - IW'(NUM_MASTERS);
      if (!w_found && m_request[w_idx[MST_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[MST_W-1:0];
      end
    end
  end

  always_comb begin
    w_onehot  = '0;
    w_win_sel = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (MST_W'(j) == w_winner) begin
        w_onehot[j] = 1'b1;
        w_win_sel   = m_slave_sel[j*SEL_W +: SEL_W];
      end
    end
  end

  assign w_bad_sel   = int'(w_win_sel) >= NUM_SLAVES;
  assign w_owner_req = m_request[r_owner];

`ifdef ARB_TIMEOUT_EN
  // Counter holds the number of GRANT cycles already completed; it sits at zero
  // outside GRANT, which makes it clear on every entry to GRANT.
  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt <= '0;
    end else if (r_state != ST_GRANT) begin
      r_cnt <= '0;
    end else if (!w_expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign w_expire = (r_state == ST_GRANT) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // A completion or abort in the expiry cycle is an ordinary release.
  assign timeout  = w_expire && !trans_done && w_owner_req;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign w_release = (r_state == ST_GRANT) && (trans_done || !w_owner_req || w_expire);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_owner <= '0;
      r_sel   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|m_request) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (!w_found) begin
            r_state <= ST_IDLE;
          end else if (w_bad_sel) begin
            r_ptr   <= next_ptr(w_winner);
            r_state <= ST_IDLE;
          end else begin
            r_owner <= w_winner;
            r_sel   <= w_win_sel;
            r_grant <= w_onehot;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Outputs are cleared on the way out so RELEASE already shows them at 0;
          // the owner is still available here to advance the pointer.
          if (w_release) begin
            r_ptr   <= next_ptr(r_owner);
            r_grant <= '0;
            r_owner <= '0;
            r_sel   <= '0;
            r_state <= ST_RELEASE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_grant      = r_grant;
  assign bus_grant    = r_owner;
  assign slave_sel    = r_sel;
  assign bus_valid    = (r_state == ST_GRANT);
  assign bus_busy     = (r_state == ST_GRANT);
  assign arbiter_busy = (r_state == ST_ARB) || (r_state == ST_RELEASE);
  assign decode_err   = (r_state == ST_ARB) && w_found && w_bad_sel;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - self-checking bench for bus_arbiter_rr (3 masters, 3 slaves)
module tb_bus_arbiter_rr;

  localparam int NM  = 3;
  localparam int NSL = 3;
  localparam int SW  = 2;
  localparam int TO  = 8;

  logic          sys_clk;
  logic          sys_rst;
  logic [NM-1:0] in_req;
  logic [NM*SW-1:0] in_sel;
  logic          in_done;

  logic [NM-1:0] m_grant;
  logic [1:0]    bus_grant;
  logic [SW-1:0] slave_sel;
  logic          bus_valid, arbiter_busy, bus_busy, decode_err, timeout;

  int n_checks;
  int n_errors;

  bus_arbiter_rr #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NSL), .MST_W(2), .SEL_W(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .m_request(in_req), .m_slave_sel(in_sel),
    .trans_done(in_done), .m_grant(m_grant), .bus_grant(bus_grant), .slave_sel(slave_sel),
    .bus_valid(bus_valid), .arbiter_busy(arbiter_busy), .bus_busy(bus_busy),
    .decode_err(decode_err), .timeout(timeout)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // Reference model: arbitration phase plus pointer/owner bookkeeping.
  typedef enum int {P_IDLE, P_ARB, P_GRANT, P_REL} phase_e;
  phase_e md_phase;
  int md_ptr, md_owner, md_ssel, md_gcnt;

  function automatic int sel_of(int m);
    return int'(in_sel[m*SW +: SW]);
  endfunction

  function automatic int winner();
    for (int k = 0; k < NM; k++) begin
      if (in_req[(md_ptr + k) % NM]) return (md_ptr + k) % NM;
    end
    return -1;
  endfunction

  function automatic bit exp_timeout();
`ifdef ARB_TIMEOUT_EN
    return (md_phase == P_GRANT) && (md_gcnt + 1 == TO) && !in_done && in_req[md_owner];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    md_phase = P_IDLE; md_ptr = 0; md_owner = 0; md_ssel = 0; md_gcnt = 0;
  endtask

  task automatic model_step();
    int w;
    case (md_phase)
      P_IDLE: if (in_req != 0) md_phase = P_ARB;
      P_ARB: begin
        w = winner();
        if (w < 0) md_phase = P_IDLE;
        else if (sel_of(w) >= NSL) begin
          md_ptr = (w + 1) % NM;
          md_phase = P_IDLE;
        end else begin
          md_owner = w; md_ssel = sel_of(w); md_gcnt = 0; md_phase = P_GRANT;
        end
      end
      P_GRANT: begin
        if (in_done || !in_req[md_owner] || exp_timeout()) begin
          md_ptr = (md_owner + 1) % NM;
          md_phase = P_REL;
        end else md_gcnt++;
      end
      default: md_phase = P_IDLE;
    endcase
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [NM-1:0] r, input logic [NM*SW-1:0] s, input logic d);
    in_req = r; in_sel = s; in_done = d;
  endtask

  // Sample at the falling edge and compare every output with the model.
  task automatic at_neg();
    logic [NM-1:0] eg;
    bit gr;
    int w;
    @(negedge sys_clk);
    gr = (md_phase == P_GRANT);
    eg = gr ? NM'(1 << md_owner) : '0;
    w  = winner();
    check("mdl_m_grant", m_grant, eg);
    check("mdl_bus_grant", bus_grant, gr ? md_owner : 0);
    check("mdl_slave_sel", slave_sel, gr ? md_ssel : 0);
    check("mdl_bus_valid", bus_valid, gr);
    check("mdl_bus_busy", bus_busy, gr);
    check("mdl_arbiter_busy", arbiter_busy, (md_phase == P_ARB) || (md_phase == P_REL));
    check("mdl_decode_err", decode_err, (md_phase == P_ARB) && (w >= 0) && (sel_of(w) >= NSL));
    check("mdl_timeout", timeout, exp_timeout());
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input logic [NM-1:0] r, input logic [NM*SW-1:0] s, input logic d);
    set_in(r, s, d);
    at_neg();
  endtask

  typedef struct {
    logic [2:0] req; logic [5:0] sel; logic done;
    logic [2:0] grant; logic [1:0] bg; logic [1:0] ss; logic busy; logic abusy;
  } vec_t;

  vec_t tbl[27];

  initial begin
    n_checks = 0; n_errors = 0;

    // master0 -> slave 2 only, then masters 0/1 alternating; ptr ends at 2
    tbl[0]  = '{3'b001, 6'h02, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{3'b001, 6'h02, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[2]  = '{3'b001, 6'h02, 1'b0, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[3]  = '{3'b001, 6'h02, 1'b0, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{3'b001, 6'h02, 1'b1, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{3'b000, 6'h02, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{3'b000, 6'h02, 1'b1, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{3'b011, 6'h06, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{3'b011, 6'h06, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[9]  = '{3'b011, 6'h06, 1'b0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[10] = '{3'b011, 6'h06, 1'b0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[11] = '{3'b011, 6'h06, 1'b0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[12] = '{3'b011, 6'h06, 1'b1, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[13] = '{3'b011, 6'h06, 1'b1, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[14] = '{3'b011, 6'h06, 1'b1, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{3'b011, 6'h06, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[16] = '{3'b011, 6'h06, 1'b0, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[17] = '{3'b011, 6'h05, 1'b0, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[18] = '{3'b011, 6'h05, 1'b0, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[19] = '{3'b011, 6'h05, 1'b1, 3'b001, 2'd0, 2'd2, 1'b1, 1'b0};
    tbl[20] = '{3'b011, 6'h05, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[21] = '{3'b011, 6'h05, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[22] = '{3'b011, 6'h05, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[23] = '{3'b011, 6'h05, 1'b0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[24] = '{3'b011, 6'h05, 1'b1, 3'b010, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[25] = '{3'b000, 6'h05, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b1};
    tbl[26] = '{3'b000, 6'h05, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0};

    // reset state
    sys_rst = 1'b0;
    set_in('0, '0, 1'b0);
    model_reset();
    @(negedge sys_clk);
    check("rst_m_grant", m_grant, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_arbiter_busy", arbiter_busy, 0);
    check("rst_bus_busy", bus_busy, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;

    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].req, tbl[i].sel, tbl[i].done);
      check($sformatf("tbl%0d_m_grant", i), m_grant, tbl[i].grant);
      check($sformatf("tbl%0d_bus_grant", i), bus_grant, tbl[i].bg);
      check($sformatf("tbl%0d_slave_sel", i), slave_sel, tbl[i].ss);
      check($sformatf("tbl%0d_bus_busy", i), bus_busy, tbl[i].busy);
      check($sformatf("tbl%0d_bus_valid", i), bus_valid, tbl[i].busy);
      check($sformatf("tbl%0d_arbiter_busy", i), arbiter_busy, tbl[i].abusy);
      check($sformatf("tbl%0d_decode_err", i), decode_err, 0);
      tick();
    end

    // grant master2 so ptr wraps to 0
    cyc(3'b100, 6'h00, 1'b0); tick();
    cyc(3'b100, 6'h00, 1'b0); tick();
    cyc(3'b100, 6'h00, 1'b1); check("wrap_m_grant", m_grant, 3'b100); tick();
    cyc(3'b000, 6'h00, 1'b0); tick();
    cyc(3'b000, 6'h00, 1'b0); tick();

    // decode error: master1 selects slave 3
    cyc(3'b010, 6'h0C, 1'b0); check("dec_idle", decode_err, 0); tick();
    cyc(3'b010, 6'h0C, 1'b0); check("dec_pulse", decode_err, 1);
    check("dec_no_grant", m_grant, 0); tick();
    cyc(3'b000, 6'h0C, 1'b0); check("dec_once", decode_err, 0);
    check("dec_idle_grant", m_grant, 0); tick();
    // next search starts at master 2
    cyc(3'b111, 6'h24, 1'b0); tick();
    cyc(3'b111, 6'h24, 1'b0); tick();
    cyc(3'b111, 6'h24, 1'b1); check("dec_next_grant", m_grant, 3'b100);
    check("dec_next_bg", bus_grant, 2); check("dec_next_ss", slave_sel, 2); tick();
    cyc(3'b000, 6'h24, 1'b0); tick();
    cyc(3'b000, 6'h24, 1'b0); tick();

    // abort: master0 drops request, master1 queued
    cyc(3'b011, 6'h04, 1'b0); tick();
    cyc(3'b011, 6'h04, 1'b0); tick();
    cyc(3'b011, 6'h04, 1'b0); check("abt_grant0", m_grant, 3'b001); tick();
    cyc(3'b010, 6'h04, 1'b0); tick();
    cyc(3'b010, 6'h04, 1'b0); check("abt_release", m_grant, 0);
    check("abt_release_busy", bus_busy, 0); tick();
    cyc(3'b010, 6'h04, 1'b0); tick();
    cyc(3'b010, 6'h04, 1'b0); check("abt_arb_grant", m_grant, 0); tick();
    cyc(3'b010, 6'h04, 1'b1); check("abt_grant1", m_grant, 3'b010); tick();
    cyc(3'b000, 6'h04, 1'b0); tick();
    cyc(3'b000, 6'h04, 1'b0); tick();

    // long grant without trans_done
    cyc(3'b001, 6'h00, 1'b0); tick();
    cyc(3'b001, 6'h00, 1'b0); tick();
`ifdef ARB_TIMEOUT_EN
    for (int g = 1; g <= TO; g++) begin
      cyc(3'b001, 6'h00, 1'b0);
      check($sformatf("to_cycle%0d", g), timeout, (g == TO));
      check($sformatf("to_grant%0d", g), m_grant, 3'b001);
      tick();
    end
    cyc(3'b011, 6'h04, 1'b0); check("to_release", m_grant, 0);
    check("to_pulse_end", timeout, 0); tick();
    cyc(3'b011, 6'h04, 1'b0); tick();
    cyc(3'b011, 6'h04, 1'b0); tick();
    cyc(3'b011, 6'h04, 1'b1); check("to_ptr_adv", m_grant, 3'b010); tick();
`else
    for (int g = 1; g <= 20; g++) begin
      cyc(3'b001, 6'h00, 1'b0);
      check($sformatf("hold_grant%0d", g), m_grant, 3'b001);
      check($sformatf("hold_timeout%0d", g), timeout, 0);
      tick();
    end
`endif
    cyc(3'b000, 6'h00, 1'b0); tick();
    cyc(3'b000, 6'h00, 1'b0); tick();

    // asynchronous reset mid-grant; ptr is 1 beforehand
    cyc(3'b001, 6'h00, 1'b0); tick();
    cyc(3'b001, 6'h00, 1'b0); tick();
    cyc(3'b001, 6'h00, 1'b1); tick();
    cyc(3'b000, 6'h00, 1'b0); tick();
    cyc(3'b010, 6'h04, 1'b0); tick();
    cyc(3'b010, 6'h04, 1'b0); tick();
    cyc(3'b010, 6'h04, 1'b0); check("rstg_pre", m_grant, 3'b010);
    #2 sys_rst = 1'b0;
    #1;
    model_reset();
    check("rstg_m_grant", m_grant, 0);
    check("rstg_bus_busy", bus_busy, 0);
    check("rstg_bus_valid", bus_valid, 0);
    check("rstg_bus_grant", bus_grant, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    cyc(3'b011, 6'h04, 1'b0); tick();
    cyc(3'b011, 6'h04, 1'b0); tick();
    cyc(3'b011, 6'h04, 1'b1); check("rstg_restart", m_grant, 3'b001); tick();
    cyc(3'b000, 6'h04, 1'b0); tick();

    // randomized traffic against the model
    begin
      logic [NM-1:0] r;
      logic [NM*SW-1:0] s;
      r = '0; s = '0;
      for (int c = 0; c < 3000; c++) begin
        for (int m = 0; m < NM; m++) begin
          if ($urandom_range(7) == 0) r[m] = ~r[m];
          if ($urandom_range(3) == 0) s[m*SW +: SW] = SW'($urandom_range(3));
        end
        cyc(r, s, ($urandom_range(5) == 0));
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
